executor_scheduler: RTL and testbench

- Sequences the four piece executors (gravity/down, rotate, move-left, move-right) that share the current-state memory write port.
- Latches player/gravity requests, dispatches one executor at a time with a one-cycle valid, and waits for that executor's done.
- Drives the one-hot grant that steers the shared write mux (type/angle/position/set_v) to the active executor.
- Sits between the input/timer logic and the executor bank.

---
 rtl/executor_scheduler.sv | 129 ++++++++++++
 tb/tb_executor_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/executor_scheduler.sv
// Dispatches the four piece executors one at a time over the shared write port.
// Ports: clk_i/reset_n_i, enable_i, req_i, exec_done_i -> exec_v_o, grant_o, busy_o, timeout_o, err_o, coalesce_cnt_o.
module executor_scheduler #(
  parameter int num_exec_p  = 4,
  parameter int timeout_p   = 255,
  parameter int cnt_width_p = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   enable_i,
  input  logic [num_exec_p-1:0]  req_i,
  input  logic [num_exec_p-1:0]  exec_done_i,
  output logic [num_exec_p-1:0]  exec_v_o,
  output logic [num_exec_p-1:0]  grant_o,
  output logic                   busy_o,
  output logic                   timeout_o,
  output logic                   err_o,
  output logic [cnt_width_p-1:0] coalesce_cnt_o
);

  localparam int sel_w_lp = (num_exec_p > 1) ? $clog2(num_exec_p) : 1;
  localparam int sum_w_lp = cnt_width_p + num_exec_p;

  typedef enum logic [1:0] {
    eIDLE  = 2'd0,
    eIssue = 2'd1,
    eWait  = 2'd2
  } state_e;

  state_e                state_r, state_n;
  logic [sel_w_lp-1:0]   sel_r, sel_n;
  logic [15:0]           timer_r, timer_n;
  logic [num_exec_p-1:0] pending_r, pending_n;
  logic                  err_r, err_n;
  logic [cnt_width_p-1:0] cnt_r, cnt_n;

  logic [num_exec_p-1:0] sel_oh;
  logic [num_exec_p-1:0] clr;
  logic [num_exec_p-1:0] drop;
  logic [sel_w_lp-1:0]   low_idx;
  logic [sum_w_lp-1:0]   cnt_sum;
  logic                  sel_done;
  logic                  to_hit;

  assign sel_oh   = num_exec_p'(1) << sel_r;
  assign sel_done = exec_done_i[sel_r];
  assign to_hit   = (state_r == eWait) &&
                    (timer_r == 16'(timeout_p - 1)) &&
                    !sel_done;

  assign clr  = (state_r == eIssue) ? sel_oh : '0;
  assign drop = req_i & pending_r & ~clr;

  // Lowest pending index wins.
  always_comb begin
    low_idx = '0;
    for (int i = num_exec_p - 1; i >= 0; i--) begin
      if (pending_r[i]) low_idx = sel_w_lp'(i);
    end
  end

  // Several bits may be dropped in one cycle; each counts once.
  always_comb begin
    cnt_sum = sum_w_lp'(cnt_r);
    for (int i = 0; i < num_exec_p; i++) begin
      cnt_sum = cnt_sum + sum_w_lp'(drop[i]);
    end
  end

  always_comb begin
    pending_n = (pending_r & ~clr) | req_i;
    if (|cnt_sum[sum_w_lp-1:cnt_width_p]) cnt_n = '1;
    else                                 cnt_n = cnt_sum[cnt_width_p-1:0];
    if (!enable_i) begin
      pending_n = '0;
      cnt_n     = cnt_r;
    end
  end

  always_comb begin
    state_n = state_r;
    sel_n   = sel_r;
    timer_n = timer_r;
    err_n   = err_r | to_hit;
    unique case (state_r)
      eIDLE: begin
        if (enable_i && |pending_r) begin
          sel_n   = low_idx;
          state_n = eIssue;
        end
      end
      eIssue: begin
        timer_n = '0;
        state_n = sel_done ? eIDLE : eWait;
      end
      eWait: begin
        timer_n = timer_r + 16'd1;
        if (sel_done || to_hit) state_n = eIDLE;
      end
      default: state_n = eIDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r   <= eIDLE;
      sel_r     <= '0;
      timer_r   <= '0;
      pending_r <= '0;
      err_r     <= 1'b0;
      cnt_r     <= '0;
    end else begin
      state_r   <= state_n;
      sel_r     <= sel_n;
      timer_r   <= timer_n;
      pending_r <= pending_n;
      err_r     <= err_n;
      cnt_r     <= cnt_n;
    end
  end

  assign exec_v_o       = (state_r == eIssue) ? sel_oh : '0;
  assign grant_o        = (state_r != eIDLE) ? sel_oh : '0;
  assign busy_o         = (state_r != eIDLE);
  assign timeout_o      = to_hit;
  assign err_o          = err_r;
  assign coalesce_cnt_o = cnt_r;

endmodule

// File: tb/tb_executor_scheduler.sv
// Randomised and directed bench for executor_scheduler.
// Compares every cycle against a transaction-level model of the dispatcher.
module tb_executor_scheduler;

  localparam int N  = 4;
  localparam int T  = 8;
  localparam int CW = 8;

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic          enable_i;
  logic [N-1:0]  req_i;
  logic [N-1:0]  exec_done_i;
  logic [N-1:0]  exec_v_o;
  logic [N-1:0]  grant_o;
  logic          busy_o;
  logic          timeout_o;
  logic          err_o;
  logic [CW-1:0] coalesce_cnt_o;

  executor_scheduler #(
    .num_exec_p (N),
    .timeout_p  (T),
    .cnt_width_p(CW)
  ) dut (
    .clk_i         (clk_i),
    .reset_n_i     (reset_n_i),
    .enable_i      (enable_i),
    .req_i         (req_i),
    .exec_done_i   (exec_done_i),
    .exec_v_o      (exec_v_o),
    .grant_o       (grant_o),
    .busy_o        (busy_o),
    .timeout_o     (timeout_o),
    .err_o         (err_o),
    .coalesce_cnt_o(coalesce_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // model: active op index (-1 none) and cycles since its issue
  int       m_op;
  int       m_age;
  bit [3:0] m_pend;
  bit       m_err;
  int       m_cnt;

  // executor responder: -2 random, -1 never done, >=0 fixed delay
  int       dly_mode;
  int       dly;
  bit       noise_en;
  logic [3:0] done_hold;

  int v_hits [4];
  int g_cyc  [4];
  int order  [$];
  int t_issue;
  int t_to;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, obs, exp, cyc);
    end
  endtask

  function automatic int lowest(input bit [3:0] p);
    for (int i = 0; i < 4; i++) if (p[i]) return i;
    return -1;
  endfunction

  task automatic clear_stats();
    for (int i = 0; i < 4; i++) begin
      v_hits[i] = 0;
      g_cyc[i]  = 0;
    end
    order.delete();
    t_issue = -100;
    t_to    = -1000;
  endtask

  task automatic model_reset();
    m_op   = -1;
    m_age  = 0;
    m_pend = '0;
    m_err  = 1'b0;
    m_cnt  = 0;
  endtask

  task automatic step(input logic [3:0] req, input logic en);
    logic [3:0] d;
    logic [3:0] ev;
    logic [3:0] eg;
    bit dn;
    bit to;
    int clr;
    int lo;
    @(negedge clk_i);
    d = noise_en ? 4'($urandom) : 4'h0;
    d = d | done_hold;
    if (m_op >= 0) begin
      if (m_age == 0) begin
        if (dly_mode == -2)
          dly = ($urandom % 10 == 0) ? -1 : int'($urandom_range(0, 5));
        else
          dly = dly_mode;
      end
      d[m_op] = (dly >= 0 && m_age == dly);
    end
    req_i       = req;
    enable_i    = en;
    exec_done_i = d;
    #1;
    dn = (m_op >= 0) && d[m_op];
    to = (m_op >= 0) && (m_age == T) && !dn;
    ev = (m_op >= 0 && m_age == 0) ? 4'(1 << m_op) : 4'h0;
    eg = (m_op >= 0) ? 4'(1 << m_op) : 4'h0;
    check("exec_v", 32'(exec_v_o), 32'(ev));
    check("grant", 32'(grant_o), 32'(eg));
    check("busy", 32'(busy_o), 32'(m_op >= 0));
    check("timeout", 32'(timeout_o), 32'(to));
    check("err", 32'(err_o), 32'(m_err));
    check("coalesce", 32'(coalesce_cnt_o), 32'(m_cnt));
    check("onehot", 32'($countones(exec_v_o) <= 1 &&
                        $countones(grant_o) <= 1), 32'(1));
    for (int i = 0; i < 4; i++) begin
      if (exec_v_o[i]) begin
        v_hits[i]++;
        order.push_back(i);
        t_issue = cyc;
      end
      if (grant_o[i]) g_cyc[i]++;
    end
    if (timeout_o) t_to = cyc;
    clr = (m_op >= 0 && m_age == 0) ? m_op : -1;
    lo  = lowest(m_pend);
    if (!en) begin
      m_pend = '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (req[i] && m_pend[i] && i != clr && m_cnt < 255) m_cnt++;
        m_pend[i] = (m_pend[i] && i != clr) || req[i];
      end
    end
    if (m_op < 0) begin
      if (en && lo >= 0) begin
        m_op  = lo;
        m_age = 0;
      end
    end else if (dn || to) begin
      if (to) m_err = 1'b1;
      m_op = -1;
    end else begin
      m_age++;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'h0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    #2;
    reset_n_i = 1'b0;
    #1;
    check("rst_exec_v", 32'(exec_v_o), 32'(0));
    check("rst_grant", 32'(grant_o), 32'(0));
    check("rst_busy", 32'(busy_o), 32'(0));
    check("rst_timeout", 32'(timeout_o), 32'(0));
    check("rst_err", 32'(err_o), 32'(0));
    check("rst_cnt", 32'(coalesce_cnt_o), 32'(0));
    req_i       = '0;
    enable_i    = 1'b0;
    exec_done_i = '0;
    @(negedge clk_i);
    reset_n_i = 1'b1;
    model_reset();
  endtask

  initial begin
    int t_req;
    int sum;
    reset_n_i   = 1'b0;
    enable_i    = 1'b0;
    req_i       = '0;
    exec_done_i = '0;
    noise_en    = 1'b0;
    done_hold   = '0;
    dly_mode    = 3;
    dly         = 0;
    model_reset();
    clear_stats();
    #12;
    do_reset();

    // single rotate request, done 3 cycles after start
    dly_mode = 3;
    clear_stats();
    t_req = cyc;
    step(4'b0010, 1'b1);
    idle(8);
    check("t1_latency", 32'(t_issue - t_req), 32'(2));
    check("t1_grant_cycles", 32'(g_cyc[1]), 32'(4));
    check("t1_busy_end", 32'(busy_o), 32'(0));

    // all four at once: fixed priority order
    dly_mode = 2;
    clear_stats();
    step(4'b1111, 1'b1);
    idle(20);
    check("t2_count", 32'(order.size()), 32'(4));
    for (int i = 0; i < 4 && i < order.size(); i++)
      check("t2_order", 32'(order[i]), 32'(i));
    check("t2_coalesce", 32'(coalesce_cnt_o), 32'(0));

    // done already high at issue
    dly_mode  = 0;
    done_hold = 4'b0010;
    clear_stats();
    step(4'b0010, 1'b1);
    idle(5);
    done_hold = '0;
    check("t3_grant_cycles", 32'(g_cyc[1]), 32'(1));
    check("t3_dispatch", 32'(v_hits[1]), 32'(1));

    // timeout on left executor
    dly_mode = -1;
    clear_stats();
    step(4'b0100, 1'b1);
    idle(12);
    check("t4_to_delay", 32'(t_to - t_issue), 32'(T));
    check("t4_err", 32'(err_o), 32'(1));
    dly_mode = 2;
    clear_stats();
    step(4'b0001, 1'b1);
    idle(6);
    check("t4_after", 32'(v_hits[0]), 32'(1));
    check("t4_err_sticky", 32'(err_o), 32'(1));

    // coalescing while executor 0 is stuck
    do_reset();
    dly_mode = -1;
    clear_stats();
    step(4'b0001, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    for (int i = 0; i < 5; i++) step(4'b1000, 1'b1);
    dly_mode = 2;
    idle(15);
    check("t5_dispatch3", 32'(v_hits[3]), 32'(1));
    check("t5_coalesce", 32'(coalesce_cnt_o), 32'(4));
    dly_mode = -1;
    for (int i = 0; i < 320; i++) step(4'b1001, 1'b1);
    dly_mode = 2;
    idle(30);
    check("t5_saturate", 32'(coalesce_cnt_o), 32'(255));

    // enable drop mid-operation
    do_reset();
    dly_mode = 6;
    step(4'b0001, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    clear_stats();
    step(4'b0110, 1'b1);
    for (int i = 0; i < 10; i++) step(4'b0000, 1'b0);
    idle(10);
    sum = v_hits[0] + v_hits[1] + v_hits[2] + v_hits[3];
    check("t6_no_dispatch", 32'(sum), 32'(0));
    check("t6_completed", 32'(g_cyc[0]), 32'(6));

    // reset in the middle of a wait
    dly_mode = -1;
    step(4'b0001, 1'b1);
    idle(4);
    check("t6_busy_pre", 32'(busy_o), 32'(1));
    do_reset();

    // randomised traffic
    noise_en = 1'b1;
    dly_mode = -2;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom % 700 == 0) do_reset();
      step(4'($urandom) & 4'($urandom) & 4'($urandom),
           ($urandom % 25) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
